// File: rtl/ulpi_rx_framer_pkg.sv
// Shared types and constants for the ULPI receive framer.
package ulpi_rx_framer_pkg;

    // Tag carried alongside every byte in the output stream.
    typedef enum logic [1:0] {
        TagData = 2'b00,
        TagCmd  = 2'b01,
        TagSop  = 2'b10,
        TagEop  = 2'b11
    } tag_e;

    // Decoder state.
    typedef enum logic [1:0] {
        StIdle = 2'b00,
        StTurn = 2'b01,
        StBus  = 2'b10,
        StPkt  = 2'b11
    } state_e;

    // RxEvent field of an RX CMD (bits 5:4).
    localparam logic [1:0] RxEvActive = 2'b01;
    localparam logic [1:0] RxEvError  = 2'b11;

    // Flag positions inside the EOP byte.
    localparam int unsigned EopErrBit   = 7;
    localparam int unsigned EopOvfBit   = 6;
    localparam int unsigned EopTruncBit = 5;
    localparam int unsigned EopAbortBit = 4;

    localparam int unsigned EntryW = 10;

    typedef struct packed {
        tag_e       tag;
        logic [7:0] data;
    } entry_t;

    function automatic logic [7:0] eop_flags(input logic err, input logic ovf,
                                             input logic trunc, input logic abort);
        logic [7:0] f;
        f              = '0;
        f[EopErrBit]   = err;
        f[EopOvfBit]   = ovf;
        f[EopTruncBit] = trunc;
        f[EopAbortBit] = abort;
        return f;
    endfunction

endpackage

// File: rtl/ulpi_rx_framer_fifo.sv
// Synchronous first-word-fall-through FIFO with an explicit occupancy count.
module ulpi_rx_framer_fifo #(
    parameter int unsigned WIDTH = 10,
    parameter int unsigned DEPTH = 16
) (
    input  logic                           i_clk,
    input  logic                           i_rst,
    input  logic                           i_push,
    input  logic [WIDTH-1:0]               i_wdata,
    input  logic                           i_pop,
    output logic [WIDTH-1:0]               o_rdata,
    output logic                           o_valid,
    output logic [$clog2(DEPTH+1)-1:0]     o_count
);

    localparam int unsigned PtrW = $clog2(DEPTH);
    localparam int unsigned CntW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PtrW-1:0]  r_wr_ptr;
    logic [PtrW-1:0]  r_rd_ptr;
    logic [CntW-1:0]  r_count;
    logic             w_full;
    logic             w_empty;
    logic             w_do_push;
    logic             w_do_pop;

    assign w_full    = (r_count == CntW'(DEPTH));
    assign w_empty   = (r_count == '0);
    assign w_do_pop  = i_pop && !w_empty;
    // A push into a full FIFO is still legal when the head leaves on the same edge.
    assign w_do_push = i_push && (!w_full || w_do_pop);

    assign o_rdata = r_mem[r_rd_ptr];
    assign o_valid = !w_empty;
    assign o_count = r_count;

    // Storage array write, no reset needed for payload.
    always_ff @(posedge i_clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= i_wdata;
        end
    end

    // Pointer and count bookkeeping; pointers wrap at the power-of-two depth.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + PtrW'(1);
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + PtrW'(1);
            if (w_do_push && !w_do_pop) begin
                r_count <= r_count + CntW'(1);
            end else if (!w_do_push && w_do_pop) begin
                r_count <= r_count - CntW'(1);
            end
        end
    end

endmodule

// File: rtl/ulpi_rx_framer.sv
// Passive ULPI receive decoder: turns PHY-driven cycles into a tagged byte stream.
module ulpi_rx_framer
    import ulpi_rx_framer_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH = 16,
    parameter int unsigned CMD_PASS   = 1,
    parameter int unsigned MAX_PKT    = 1024,
    parameter int unsigned LEN_W      = 11
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic [7:0]       i_ulpi_data,
    input  logic             i_ulpi_dir,
    input  logic             i_ulpi_nxt,
    output logic [7:0]       o_out_data,
    output logic [1:0]       o_out_tag,
    output logic             o_out_valid,
    input  logic             i_out_ready,
    output logic [1:0]       o_line_state,
    output logic [1:0]       o_vbus_state,
    output logic             o_rx_active,
    output logic [LEN_W-1:0] o_pkt_len,
    output logic [7:0]       o_pkt_drop,
    output logic             o_overflow
);

    localparam int unsigned      CntW   = $clog2(FIFO_DEPTH + 1);
    localparam logic [LEN_W-1:0] MaxLen = LEN_W'(MAX_PKT);

    logic [7:0]       r_s1_data;
    logic             r_s1_dir;
    logic             r_s1_nxt;
    state_e           r_state;
    state_e           w_state_next;
    logic [1:0]       w_rx_event;

    // FSM action strobes
    logic w_start, w_data, w_cmd, w_rxcmd, w_end, w_abort, w_set_err;

    // Per-packet context
    logic             r_drop, r_err, r_ovf_pkt, r_trunc;
    logic [LEN_W-1:0] r_len;

    // Status registers
    logic [1:0]       r_line_state, r_vbus_state;
    logic [LEN_W-1:0] r_pkt_len;
    logic [7:0]       r_pkt_drop;
    logic             r_overflow;

    // Space accounting and write path
    logic [CntW-1:0]  w_count;
    logic [31:0]      w_used;
    logic             w_room_sop, w_room_byte;
    logic             w_sop_ok, w_sop_rej, w_data_ok, w_data_lost;
    logic             w_cmd_ok, w_cmd_lost, w_eop_ok, w_skid_clash;
    entry_t           w_new_a, w_new_b;
    logic [1:0]       w_new_cnt;
    entry_t           r_skid;
    logic             r_skid_v;
    logic             w_push;
    entry_t           w_wdata;
    logic [EntryW-1:0] w_rdata;

    assign w_rx_event = r_s1_data[5:4];

    // S1: single registration of the bus, the FSM only looks at this copy.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_s1_data <= '0;
            r_s1_dir  <= 1'b0;
            r_s1_nxt  <= 1'b0;
        end else begin
            r_s1_data <= i_ulpi_data;
            r_s1_dir  <= i_ulpi_dir;
            r_s1_nxt  <= i_ulpi_nxt;
        end
    end

    // FSM state register.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) r_state <= StIdle;
        else       r_state <= w_state_next;
    end

    // FSM next-state decode.
    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            StIdle: if (r_s1_dir) w_state_next = StTurn;
            StTurn: begin
                if (!r_s1_dir)     w_state_next = StIdle;
                else if (r_s1_nxt) w_state_next = StPkt;
                else               w_state_next = StBus;
            end
            StBus: begin
                if (!r_s1_dir)                          w_state_next = StIdle;
                else if (r_s1_nxt || w_rx_event[0])     w_state_next = StPkt;
            end
            StPkt: begin
                if (!r_s1_dir)                          w_state_next = StIdle;
                else if (!r_s1_nxt && !w_rx_event[0])   w_state_next = StBus;
            end
        endcase
    end

    // FSM action outputs for the cycle currently held in S1.
    always_comb begin
        w_start   = 1'b0;
        w_data    = 1'b0;
        w_cmd     = 1'b0;
        w_rxcmd   = 1'b0;
        w_end     = 1'b0;
        w_abort   = 1'b0;
        w_set_err = 1'b0;
        unique case (r_state)
            StIdle: ;
            StTurn: w_start = r_s1_dir && r_s1_nxt;
            StBus: begin
                if (r_s1_dir && !r_s1_nxt) begin
                    w_rxcmd = 1'b1;
                    // An RX CMD that opens a packet becomes the SOP, not a CMD entry.
                    if (w_rx_event == RxEvActive || w_rx_event == RxEvError) w_start = 1'b1;
                    else                                                      w_cmd   = 1'b1;
                end else if (r_s1_dir) begin
                    w_start = 1'b1;
                    w_data  = 1'b1;
                end
            end
            StPkt: begin
                if (!r_s1_dir) begin
                    w_end   = 1'b1;
                    w_abort = 1'b1;
                end else if (r_s1_nxt) begin
                    w_data = 1'b1;
                end else begin
                    w_rxcmd   = 1'b1;
                    w_set_err = (w_rx_event == RxEvError);
                    w_end     = !w_rx_event[0];
                end
            end
        endcase
    end

    assign o_rx_active = (r_state == StPkt);

    // The skid entry is already committed, so it counts against free space.
    assign w_used      = 32'(w_count) + 32'(r_skid_v);
    assign w_room_sop  = (w_used + 32'd3) <= 32'(FIFO_DEPTH);
    assign w_room_byte = (w_used + 32'd2) <= 32'(FIFO_DEPTH);

    // Admission decisions against the space reservation rules.
    always_comb begin
        w_sop_ok    = w_start && w_room_sop;
        w_sop_rej   = w_start && !w_room_sop;
        w_data_ok   = w_data && !w_start && !r_drop && w_room_byte;
        w_data_lost = w_data && !w_start && !r_drop && !w_room_byte;
        w_cmd_ok    = w_cmd && (CMD_PASS != 0) && w_room_byte;
        w_cmd_lost  = w_cmd && (CMD_PASS != 0) && !w_room_byte;
        w_eop_ok    = w_end && !r_drop;
    end

    // Build up to two new entries; only SOP with its first DATA byte yields two.
    always_comb begin
        w_new_a   = entry_t'{tag: TagData, data: 8'h00};
        w_new_b   = entry_t'{tag: TagData, data: r_s1_data};
        w_new_cnt = 2'd0;
        if (w_sop_ok) begin
            w_new_a   = entry_t'{tag: TagSop, data: 8'h00};
            w_new_cnt = w_data ? 2'd2 : 2'd1;
        end else if (w_data_ok) begin
            w_new_a   = entry_t'{tag: TagData, data: r_s1_data};
            w_new_cnt = 2'd1;
        end else if (w_cmd_ok) begin
            w_new_a   = entry_t'{tag: TagCmd, data: r_s1_data};
            w_new_cnt = 2'd1;
        end else if (w_eop_ok) begin
            w_new_a   = entry_t'{tag: TagEop, data: eop_flags(r_err, r_ovf_pkt, r_trunc, w_abort)};
            w_new_cnt = 2'd1;
        end
    end

    // Skid drains first; a new entry arriving behind it takes its place.
    always_comb begin
        w_push       = r_skid_v || (w_new_cnt != 2'd0);
        w_wdata      = r_skid_v ? r_skid : w_new_a;
        w_skid_clash = r_skid_v && (w_new_cnt == 2'd2);
    end

    // Skid register holding the byte displaced by a same-cycle SOP.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_skid_v <= 1'b0;
            r_skid   <= entry_t'{tag: TagData, data: 8'h00};
        end else if (r_skid_v) begin
            r_skid_v <= (w_new_cnt != 2'd0);
            r_skid   <= w_new_a;
        end else begin
            r_skid_v <= (w_new_cnt == 2'd2);
            r_skid   <= w_new_b;
        end
    end

    // Per-packet flags and the saturating length counter.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_drop    <= 1'b0;
            r_err     <= 1'b0;
            r_ovf_pkt <= 1'b0;
            r_trunc   <= 1'b0;
            r_len     <= '0;
        end else if (w_sop_ok) begin
            r_drop    <= 1'b0;
            r_err     <= 1'b0;
            r_ovf_pkt <= w_skid_clash;
            r_trunc   <= 1'b0;
            r_len     <= w_data ? LEN_W'(1) : '0;
        end else begin
            if (w_sop_rej) r_drop <= 1'b1;
            if (w_data && !w_start) begin
                if (r_len == MaxLen) r_trunc <= 1'b1;
                else                 r_len   <= r_len + LEN_W'(1);
            end
            if (w_set_err)                  r_err     <= 1'b1;
            if (w_data_lost || w_cmd_lost)  r_ovf_pkt <= 1'b1;
        end
    end

    // Exported line status, packet statistics and sticky overflow.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_line_state <= '0;
            r_vbus_state <= '0;
            r_pkt_len    <= '0;
            r_pkt_drop   <= '0;
            r_overflow   <= 1'b0;
        end else begin
            if (w_rxcmd) begin
                r_line_state <= r_s1_data[1:0];
                r_vbus_state <= r_s1_data[3:2];
            end
            if (w_eop_ok) r_pkt_len <= r_len;
            if (w_sop_rej && r_pkt_drop != 8'hFF) r_pkt_drop <= r_pkt_drop + 8'd1;
            if (w_sop_rej || w_data_lost || w_cmd_lost || w_skid_clash) r_overflow <= 1'b1;
        end
    end

    ulpi_rx_framer_fifo #(
        .WIDTH (EntryW),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_push  (w_push),
        .i_wdata (w_wdata),
        .i_pop   (i_out_ready),
        .o_rdata (w_rdata),
        .o_valid (o_out_valid),
        .o_count (w_count)
    );

    assign o_out_tag    = w_rdata[9:8];
    assign o_out_data   = w_rdata[7:0];
    assign o_line_state = r_line_state;
    assign o_vbus_state = r_vbus_state;
    assign o_pkt_len    = r_pkt_len;
    assign o_pkt_drop   = r_pkt_drop;
    assign o_overflow   = r_overflow;

endmodule
